// File: rtl/serial_arith_pkg.sv
// Purpose : shared types and helpers for the bit-serial arithmetic blocks.
// Contents: FSM state encoding (sa_state_t) and the bit-counter width helper cnt_w().
// Users   : serial_adder today, a serial subtractor later.
package serial_arith_pkg;

  // Three-phase sequencing shared by every serial arithmetic block.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_t;

  // Bit-counter width for a w-bit operand.
  // The counter only runs 0..w-1, so ceil(log2(w)) bits are enough.
  // The result is floored at 1 so that a degenerate w still gives a usable width.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Purpose: operand/result handshake bundle for serial_adder.
// Ports  : in_valid/in_ready carry a, b and cin into the block.
//          out_valid/out_ready carry sum and cout out of the block; busy is a status flag.
// Modports: master drives operands and consumes results; slave is the adder itself.
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/serial_adder_cell.sv
// Purpose : one-bit full adder, purely combinational (module full_adder_cell).
// Ports   : a, b and cin are the inputs; s = a^b^cin and cout = majority(a, b, cin).
// Latency : zero cycles. There is no handshake and no backpressure.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Purpose : bit-serial unsigned adder, LSB first, one bit per clock through a single full-adder cell.
// Latency : accept at edge E, then out_valid is high after edge E+WIDTH.
//           The minimum repeat interval is WIDTH+2 cycles.
// Backpressure: the result is held in DONE until out_ready.
//           in_ready is high only in IDLE, so no new operand is taken while a result is pending.
// Ports   : clk and rst_n (asynchronous, active-low) are plain ports.
//           bus (serial_adder_if.slave) carries operands, results and busy.
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8  // legal range 2..32
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry;
  logic [CW-1:0]    count;

  logic             in_ready, out_valid, busy;
  logic             fa_s, fa_co;
  logic             accept;

  // The single arithmetic cell; the carry flop closes the loop around it.
  full_adder_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  assign accept = in_ready & bus.in_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (count == LAST) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // Returning to IDLE first means in_ready rises only the cycle after the result is taken.
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand shifters, the sum shifter, the carry flop and the bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            count <= '0;
          end
        end
        SHIFT: begin
          // Sum bits enter at the MSB.
          // After WIDTH shifts, bit 0 of the result has reached position 0.
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_co;
          // The counter saturates at the last bit, so it cannot wrap back to zero.
          if (count != LAST) count <= count + 1'b1;
        end
        default: ;  // DONE holds every register stable while the consumer stalls.
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.sum       = sum_sh;
  assign bus.cout      = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Purpose : directed, table-driven check of serial_adder, with a WIDTH=8 and a WIDTH=4 instance,
//           plus the full_adder_cell on its own.
// Flow    : inputs are driven and outputs sampled on the falling edge.
//           The DUT samples on the rising edge.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) b8 ();
  serial_adder_if #(.WIDTH(4)) b4 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  logic fa_a, fa_b, fa_c, fa_s, fa_co;
  full_adder_cell u_fa (.a(fa_a), .b(fa_b), .cin(fa_c), .s(fa_s), .cout(fa_co));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] in;   // {a, b, cin}
    logic       s;
    logic       co;
  } fa_vec_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } add_vec_t;

  // Called on a falling edge with dut8 idle.
  // Returns the result and the number of falling edges from accept to out_valid.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      output logic [7:0] s, output logic co, output int lat);
    b8.a = a; b8.b = b; b8.cin = ci; b8.in_valid = 1'b1;
    @(negedge clk);
    b8.in_valid = 1'b0;
    lat = 0;
    while (!b8.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    s  = b8.sum;
    co = b8.cout;
    b8.out_ready = 1'b1;
    @(negedge clk);
    b8.out_ready = 1'b0;
  endtask

  initial begin
    fa_vec_t    fav[8];
    add_vec_t   av[10];
    logic [7:0] s8;
    logic       c8;
    int         lat;
    int         n;
    bit         done;

    fav[0] = '{3'b000, 1'b0, 1'b0};
    fav[1] = '{3'b001, 1'b1, 1'b0};
    fav[2] = '{3'b010, 1'b1, 1'b0};
    fav[3] = '{3'b011, 1'b0, 1'b1};
    fav[4] = '{3'b100, 1'b1, 1'b0};
    fav[5] = '{3'b101, 1'b0, 1'b1};
    fav[6] = '{3'b110, 1'b0, 1'b1};
    fav[7] = '{3'b111, 1'b1, 1'b1};

    av[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    av[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    av[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    av[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    av[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    av[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    av[6] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
    av[7] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
    av[8] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    av[9] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0};

    b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.cin = 1'b0; b8.out_ready = 1'b0;
    b4.in_valid = 1'b0; b4.a = '0; b4.b = '0; b4.cin = 1'b0; b4.out_ready = 1'b0;
    fa_a = 1'b0; fa_b = 1'b0; fa_c = 1'b0;

    // Full-adder cell, all eight input combinations
    for (int i = 0; i < 8; i++) begin
      {fa_a, fa_b, fa_c} = fav[i].in;
      #1;
      chk($sformatf("fa_s[%0d]", i), 64'(fa_s), 64'(fav[i].s));
      chk($sformatf("fa_co[%0d]", i), 64'(fa_co), 64'(fav[i].co));
    end

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(b8.in_ready), 64'd1);
    chk("rst_out_valid", 64'(b8.out_valid), 64'd0);
    chk("rst_busy", 64'(b8.busy), 64'd0);
    chk("rst_sum", 64'(b8.sum), 64'd0);
    chk("rst_cout", 64'(b8.cout), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table, WIDTH=8
    for (int i = 0; i < 10; i++) begin
      run8(av[i].a, av[i].b, av[i].cin, s8, c8, lat);
      chk($sformatf("sum8[%0d]", i), 64'(s8), 64'(av[i].sum));
      chk($sformatf("cout8[%0d]", i), 64'(c8), 64'(av[i].cout));
      chk($sformatf("lat8[%0d]", i), 64'(lat), 64'd8);
    end

    // Backpressure.
    // Operands presented in SHIFT or DONE are ignored, and the result holds while stalled.
    b8.a = 8'h3C; b8.b = 8'h0F; b8.cin = 1'b0; b8.in_valid = 1'b1;
    @(negedge clk);
    b8.in_valid = 1'b0;
    @(negedge clk);
    chk("shift_busy", 64'(b8.busy), 64'd1);
    chk("shift_in_ready", 64'(b8.in_ready), 64'd0);
    b8.a = 8'hAA; b8.in_valid = 1'b1;
    @(negedge clk);
    b8.in_valid = 1'b0;
    n = 0;
    while (!b8.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_done", 64'(b8.out_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_out_valid[%0d]", k), 64'(b8.out_valid), 64'd1);
      chk($sformatf("bp_sum[%0d]", k), 64'(b8.sum), 64'h4B);
      chk($sformatf("bp_cout[%0d]", k), 64'(b8.cout), 64'd0);
      chk($sformatf("bp_in_ready[%0d]", k), 64'(b8.in_ready), 64'd0);
      b8.in_valid = k[0];
      b8.a = 8'hAA;
      @(negedge clk);
    end
    // Result handshake with in_valid high in the same cycle: no accept in DONE.
    b8.in_valid = 1'b1; b8.out_ready = 1'b1;
    @(negedge clk);
    b8.in_valid = 1'b0; b8.out_ready = 1'b0;
    chk("post_hs_busy", 64'(b8.busy), 64'd0);
    chk("post_hs_out_valid", 64'(b8.out_valid), 64'd0);
    chk("post_hs_in_ready", 64'(b8.in_ready), 64'd1);

    // Reset in the middle of SHIFT, at count=3
    b8.a = 8'hFF; b8.b = 8'h01; b8.cin = 1'b0; b8.in_valid = 1'b1;
    @(negedge clk);
    b8.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(b8.out_valid), 64'd0);
    chk("mid_rst_busy", 64'(b8.busy), 64'd0);
    chk("mid_rst_in_ready", 64'(b8.in_ready), 64'd1);
    chk("mid_rst_sum", 64'(b8.sum), 64'd0);
    chk("mid_rst_cout", 64'(b8.cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run8(8'h12, 8'h34, 1'b0, s8, c8, lat);
    chk("after_rst_sum", 64'(s8), 64'h46);
    chk("after_rst_cout", 64'(c8), 64'd0);
    chk("after_rst_lat", 64'(lat), 64'd8);

    // WIDTH=4: exhaustive a, b and cin, with randomised out_ready
    for (int x = 0; x < 512; x++) begin
      logic [4:0] exp4;
      b4.a = x[3:0]; b4.b = x[7:4]; b4.cin = x[8];
      exp4 = {1'b0, b4.a} + {1'b0, b4.b} + {4'b0, b4.cin};
      b4.in_valid = 1'b1;
      @(negedge clk);
      b4.in_valid = 1'b0;
      n = 0;
      done = 1'b0;
      while (!done && n < 60) begin
        logic r;
        r = 1'($urandom_range(0, 1));
        b4.out_ready = r;
        if (b4.out_valid && r) begin
          chk($sformatf("w4[%0d]", x), 64'({b4.cout, b4.sum}), 64'(exp4));
          done = 1'b1;
        end
        @(negedge clk);
        n++;
      end
      b4.out_ready = 1'b0;
      if (!done) begin
        chk($sformatf("w4_timeout[%0d]", x), 64'd0, 64'd1);
        break;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
